// File: rtl/machine_d_monitor_pkg.sv
// Shared constants for machine_d and its monitor: state width and default sizing.
// Ports: none (package only).
// Benches for machine_d and this monitor import the same values so they agree.
package machine_d_monitor_pkg;

   localparam int S_W         = 3;   // machine_d state width
   localparam int DEPTH_DEF   = 4;   // event FIFO entries
   localparam int CNT_W_DEF   = 8;   // rising-edge counter width
   localparam int RUN_LEN_DEF = 3;   // F-high cycles that raise the alarm

endpackage

// File: rtl/machine_d_monitor_if.sv
// Bundle of the observed machine_d signals and the monitor's event/status outputs.
// Ports: F, S, rd_en driven by the master; ev_*, overflow, f_count, run_alarm by the monitor.
// The monitor side (slave) never stalls F/S; only rd_en is a handshake toward the FIFO.
interface machine_d_monitor_if
   import machine_d_monitor_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEF
);
   logic             F;
   logic [S_W-1:0]   S;
   logic             rd_en;
   logic             ev_valid;
   logic [S_W-1:0]   ev_data;
   logic             ev_full;
   logic             overflow;
   logic [CNT_W-1:0] f_count;
   logic             run_alarm;

   modport master (
      output F, S, rd_en,
      input  ev_valid, ev_data, ev_full, overflow, f_count, run_alarm
   );

   modport slave (
      input  F, S, rd_en,
      output ev_valid, ev_data, ev_full, overflow, f_count, run_alarm
   );
endinterface

// File: rtl/machine_d_monitor_event_fifo.sv
// Generic synchronous show-ahead FIFO; dout shows the oldest entry whenever valid.
// Ports: clk/rst, push+din, pop, dout/valid/full status, drop pulse for a rejected push.
// Latency: one edge from push to valid; a push into a full FIFO is dropped unless a pop frees a slot on the same edge.
module event_fifo #(
   parameter int W     = 3,
   parameter int DEPTH = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push,
   input  logic [W-1:0] din,
   input  logic         pop,
   output logic [W-1:0] dout,
   output logic         valid,
   output logic         full,
   output logic         drop
);
   localparam int            AW       = $clog2(DEPTH);
   localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] rd_ptr;
   logic [AW-1:0] wr_ptr;
   logic [AW:0]   count;
   logic          pop_eff;
   logic          push_eff;

   assign valid    = (count != '0);
   assign full     = (count == FULL_CNT);
   // Pop on empty is ignored; a pop on full makes room for a same-edge push.
   assign pop_eff  = pop && valid;
   assign push_eff = push && (!full || pop_eff);
   assign drop     = push && full && !pop_eff;
   // Gate so dout reads zero while empty (stale storage is never exposed).
   assign dout     = valid ? mem[rd_ptr] : '0;

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_eff) wr_ptr <= wr_ptr + 1'b1;
         if (pop_eff)  rd_ptr <= rd_ptr + 1'b1;
         case ({push_eff, pop_eff})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Storage needs no reset: contents are only visible through valid.
   always_ff @(posedge clk) begin
      if (push_eff) mem[wr_ptr] <= din;
   end
endmodule

// File: rtl/machine_d_monitor.sv
// Observer for machine_d: counts F rising edges, flags long F-high runs, logs S changes.
// Ports: CLK, RESET (sync, active-high), mon (slave side of machine_d_monitor_if).
// Latency: every output updates on the edge that samples its cause; F/S are never stalled, overflowing events are dropped and flagged.
module machine_d_monitor
   import machine_d_monitor_pkg::*;
#(
   parameter int DEPTH   = DEPTH_DEF,
   parameter int CNT_W   = CNT_W_DEF,
   parameter int RUN_LEN = RUN_LEN_DEF
) (
   input logic                  CLK,
   input logic                  RESET,
   machine_d_monitor_if.slave   mon
);
   localparam int             RW      = $clog2(RUN_LEN + 1);
   localparam logic [RW-1:0]  RUN_MAX = RW'(RUN_LEN);

   logic             prev_F;
   logic [S_W-1:0]   prev_S;
   logic             prev_valid;
   logic [RW-1:0]    run_cnt;
   logic [RW-1:0]    run_nxt;
   logic [CNT_W-1:0] f_count;
   logic             run_alarm;
   logic             overflow;
   logic             push;
   logic             drop;

   // No event on the first sample after reset: prev_S is not yet meaningful.
   assign push = prev_valid && (mon.S != prev_S);

   always_comb begin
      run_nxt = run_cnt;
      if (!mon.F)
         run_nxt = '0;
      else if (run_cnt != RUN_MAX)
         run_nxt = run_cnt + 1'b1;
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         prev_F     <= 1'b0;
         prev_S     <= '0;
         prev_valid <= 1'b0;
         run_cnt    <= '0;
         run_alarm  <= 1'b0;
         f_count    <= '0;
         overflow   <= 1'b0;
      end else begin
         prev_F     <= mon.F;
         prev_S     <= mon.S;
         prev_valid <= 1'b1;
         run_cnt    <= run_nxt;
         run_alarm  <= (run_nxt == RUN_MAX);
         if (mon.F && !prev_F && (f_count != {CNT_W{1'b1}}))
            f_count <= f_count + 1'b1;
         if (drop)
            overflow <= 1'b1;
      end
   end

   event_fifo #(
      .W     (S_W),
      .DEPTH (DEPTH)
   ) u_event_fifo (
      .clk   (CLK),
      .rst   (RESET),
      .push  (push),
      .din   (mon.S),
      .pop   (mon.rd_en),
      .dout  (mon.ev_data),
      .valid (mon.ev_valid),
      .full  (mon.ev_full),
      .drop  (drop)
   );

   assign mon.f_count   = f_count;
   assign mon.run_alarm = run_alarm;
   assign mon.overflow  = overflow;
endmodule

// File: tb/tb_machine_d_monitor.sv
// Directed bench for machine_d_monitor: default instance plus a CNT_W=3 instance for saturation.
// Both instances see identical F/S/rd_en/RESET; outputs sampled 1 time unit after each rising edge.
module tb_machine_d_monitor;
   logic CLK   = 1'b0;
   logic RESET = 1'b1;

   int compared   = 0;
   int mismatched = 0;

   machine_d_monitor_if #(.CNT_W(8)) mon  ();
   machine_d_monitor_if #(.CNT_W(3)) mon3 ();

   assign mon3.F     = mon.F;
   assign mon3.S     = mon.S;
   assign mon3.rd_en = mon.rd_en;

   machine_d_monitor #(.DEPTH(4), .CNT_W(8), .RUN_LEN(3)) dut (
      .CLK   (CLK),
      .RESET (RESET),
      .mon   (mon)
   );

   machine_d_monitor #(.DEPTH(4), .CNT_W(3), .RUN_LEN(3)) dut3 (
      .CLK   (CLK),
      .RESET (RESET),
      .mon   (mon3)
   );

   always #5 CLK = ~CLK;

   bit fv [8] = '{1, 1, 0, 1, 1, 1, 1, 0};
   bit av [8] = '{0, 0, 0, 0, 0, 1, 1, 0};
   int dv [3] = '{1, 0, 1};

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   initial begin
      mon.F     = 1'b1;
      mon.S     = 3'd5;
      mon.rd_en = 1'b0;

      // Reset held two cycles with live inputs.
      tick();
      tick();
      check("rst_ev_valid",  32'(mon.ev_valid),  0);
      check("rst_ev_data",   32'(mon.ev_data),   0);
      check("rst_ev_full",   32'(mon.ev_full),   0);
      check("rst_overflow",  32'(mon.overflow),  0);
      check("rst_f_count",   32'(mon.f_count),   0);
      check("rst_run_alarm", 32'(mon.run_alarm), 0);
      check("rst_f_count3",  32'(mon3.f_count),  0);

      // First edge after release: F=1 counts, no event logged.
      RESET = 1'b0;
      tick();
      check("first_f_count",  32'(mon.f_count),  1);
      check("first_ev_valid", 32'(mon.ev_valid), 0);
      tick();
      check("held_f_count",   32'(mon.f_count),  1);
      check("held_ev_valid",  32'(mon.ev_valid), 0);

      // State-change logging: first sample 0, then 1,3,3,2.
      RESET = 1'b1; mon.F = 1'b0; mon.S = 3'd0;
      tick();
      RESET = 1'b0;
      tick();
      mon.S = 3'd1; tick();
      check("log_first_ev",  32'(mon.ev_valid), 1);
      check("log_first_dat", 32'(mon.ev_data),  1);
      mon.S = 3'd3; tick();
      mon.S = 3'd3; tick();
      mon.S = 3'd2; tick();
      check("log_head",      32'(mon.ev_data),  1);
      check("log_not_full",  32'(mon.ev_full),  0);
      mon.rd_en = 1'b1;
      tick(); check("log_pop1", 32'(mon.ev_data), 3);
      tick(); check("log_pop2", 32'(mon.ev_data), 2);
      tick(); check("log_empty", 32'(mon.ev_valid), 0);
      tick(); check("log_empty_pop_ignored", 32'(mon.ev_valid), 0);
      // Push and pop while empty: the push lands.
      mon.S = 3'd6; tick();
      check("empty_pushpop_valid", 32'(mon.ev_valid), 1);
      check("empty_pushpop_data",  32'(mon.ev_data),  6);
      tick();
      check("empty_pushpop_drain", 32'(mon.ev_valid), 0);
      mon.rd_en = 1'b0;

      // Overflow: 6 toggles into a 4-deep FIFO.
      RESET = 1'b1; mon.S = 3'd0;
      tick();
      RESET = 1'b0;
      tick();
      for (int i = 1; i <= 6; i++) begin
         mon.S = (i % 2 == 1) ? 3'd1 : 3'd0;
         tick();
         if (i == 3) check("ovf_full_at3", 32'(mon.ev_full), 0);
         if (i == 4) begin
            check("ovf_full_at4", 32'(mon.ev_full),  1);
            check("ovf_ovf_at4",  32'(mon.overflow), 0);
         end
         if (i == 5) check("ovf_ovf_at5", 32'(mon.overflow), 1);
      end
      check("ovf_head", 32'(mon.ev_data), 1);
      // Simultaneous push and pop while full.
      mon.S = 3'd1; mon.rd_en = 1'b1;
      tick();
      check("pp_full_full", 32'(mon.ev_full),  1);
      check("pp_full_ovf",  32'(mon.overflow), 1);
      check("pp_full_head", 32'(mon.ev_data),  0);
      for (int i = 0; i < 3; i++) begin
         tick();
         check("pp_drain", 32'(mon.ev_data), 32'(dv[i]));
      end
      tick();
      check("pp_drain_empty", 32'(mon.ev_valid), 0);
      check("pp_drain_ovf",   32'(mon.overflow), 1);
      mon.rd_en = 1'b0;

      // Alarm timing: F = 1,1,0,1,1,1,1,0.
      RESET = 1'b1; mon.F = 1'b0; mon.S = 3'd0;
      tick();
      RESET = 1'b0;
      for (int i = 0; i < 8; i++) begin
         mon.F = fv[i];
         tick();
         check("alarm_step", 32'(mon.run_alarm), 32'(av[i]));
      end
      check("alarm_f_count", 32'(mon.f_count), 2);

      // Saturation: 10 pulses.
      RESET = 1'b1; mon.F = 1'b0;
      tick();
      RESET = 1'b0;
      for (int i = 1; i <= 10; i++) begin
         mon.F = 1'b1; tick();
         mon.F = 1'b0; tick();
         if (i == 7) check("sat_at7_cnt3", 32'(mon3.f_count), 7);
      end
      check("sat_cnt3_holds", 32'(mon3.f_count), 7);
      check("sat_cnt8",       32'(mon.f_count),  10);

      // Reset mid-operation with 3 entries, overflow set and rd_en high.
      RESET = 1'b1; mon.S = 3'd0;
      tick();
      RESET = 1'b0;
      tick();
      mon.F = 1'b1;
      for (int i = 1; i <= 5; i++) begin
         mon.S = 3'(i);
         tick();
      end
      mon.rd_en = 1'b1;
      tick();
      mon.rd_en = 1'b0;
      check("mid_pre_head", 32'(mon.ev_data),  2);
      check("mid_pre_ovf",  32'(mon.overflow), 1);
      check("mid_pre_cnt",  32'(mon.f_count),  1);
      RESET = 1'b1; mon.rd_en = 1'b1; mon.S = 3'd7;
      tick();
      check("mid_ev_valid", 32'(mon.ev_valid), 0);
      check("mid_ev_full",  32'(mon.ev_full),  0);
      check("mid_overflow", 32'(mon.overflow), 0);
      check("mid_f_count",  32'(mon.f_count),  0);
      check("mid_ev_data",  32'(mon.ev_data),  0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
